// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned LAT_DEFAULT = 2;
    localparam int unsigned PERF_W      = 16;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        if (en && (v != {PERF_W{1'b1}})) begin
            return v + PERF_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on contention the requester not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic any
);

    assign any    = req0 | req1;
    assign winner = (req0 & req1) ? ~last : (req1 ? REQ_DM : REQ_IF);

endmodule

// File: rtl/mux2n.sv
// N-bit 2:1 steering mux.
module mux2n #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a0_i,
    input  logic [N-1:0] a1_i,
    input  logic         sel_i,
    output logic [N-1:0] y_o
);

    assign y_o = sel_i ? a1_i : a0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for one shared single-port memory (fetch vs. load/store).
// Define MEM_ARB_PERF_CNT_EN to add saturating grant and wait counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned AW  = 8,
    parameter int unsigned LAT = LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [AW-1:0]     addr0,
    input  logic [AW-1:0]     addr1,
    input  logic [N-1:0]      wdata0,
    input  logic [N-1:0]      wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [N-1:0]      rdata,
    output logic              sel,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [PERF_W-1:0] gcnt0,
    output logic [PERF_W-1:0] gcnt1,
    output logic [PERF_W-1:0] wcnt,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [N-1:0]      mem_wdata,
    input  logic [N-1:0]      mem_rdata
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    rdata_q, rdata_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic            en_q, en_d;
    logic            we_q, we_d;
    logic            winner;
    logic            any;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    mux2n #(.N(AW)) u_addr_mux (
        .a0_i  (addr0),
        .a1_i  (addr1),
        .sel_i (sel_q),
        .y_o   (mem_addr)
    );

    mux2n #(.N(N)) u_wdata_mux (
        .a0_i  (wdata0),
        .a1_i  (wdata1),
        .sel_i (sel_q),
        .y_o   (mem_wdata)
    );

    // State register; grant/enable/done are registered so they drop the instant rst asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= REQ_IF;
            last_q  <= REQ_DM;
            cnt_q   <= '0;
            rdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            en_q    <= en_d;
            we_q    <= we_d;
        end
    end

    // Next state plus next values of the registered memory-side and requester-side strobes.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        en_d    = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any) begin
                    state_d       = S_BUSY;
                    sel_d         = winner;
                    last_d        = winner;
                    cnt_d         = CW'(LAT - 1);
                    gnt_d[winner] = 1'b1;
                    en_d          = 1'b1;
                    we_d          = (winner == REQ_DM) ? we1 : we0;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d       = S_DONE;
                    rdata_d       = mem_rdata;
                    done_d[sel_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    gnt_d = gnt_q;
                    en_d  = 1'b1;
                    we_d  = we_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt0   = gnt_q[0];
    assign gnt1   = gnt_q[1];
    assign done0  = done_q[0];
    assign done1  = done_q[1];
    assign rdata  = rdata_q;
    assign sel    = sel_q;
    assign mem_en = en_q;
    assign mem_we = we_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [PERF_W-1:0] gcnt0_q, gcnt0_d;
    logic [PERF_W-1:0] gcnt1_q, gcnt1_d;
    logic [PERF_W-1:0] wcnt_q, wcnt_d;
    logic              grant_edge;
    logic              loser_pending;

    // A waiting request is the one not currently being served (or the loser of a contended pick).
    always_comb begin
        grant_edge    = (state_q == S_IDLE) && any;
        loser_pending = (state_q == S_IDLE) ? (req0 & req1) : (sel_q ? req0 : req1);
        gcnt0_d       = sat_inc(gcnt0_q, grant_edge && (winner == REQ_IF));
        gcnt1_d       = sat_inc(gcnt1_q, grant_edge && (winner == REQ_DM));
        wcnt_d        = sat_inc(wcnt_q, loser_pending);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            wcnt_q  <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
    assign wcnt  = wcnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (LAT=2); perf counters checked when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;

    localparam int unsigned N   = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [N-1:0]  wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, sel;
    logic [N-1:0]  rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0]   gcnt0, gcnt1, wcnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .AW(AW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .we0       (we0),
        .we1       (we1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .sel       (sel),
`ifdef MEM_ARB_PERF_CNT_EN
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1),
        .wcnt      (wcnt),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered in an IDLE cycle with the request already driven; returns #1 after the edge leaving DONE.
    task automatic expect_txn(input logic who, input logic [7:0] a, input logic [7:0] wd,
                              input logic w, input logic chk_rd, input logic [7:0] rd);
        @(posedge clk);
        for (int c = 1; c <= int'(LAT); c++) begin
            @(negedge clk);
            check("busy_gnt0", 32'(gnt0), 32'(!who));
            check("busy_gnt1", 32'(gnt1), 32'(who));
            check("busy_sel", 32'(sel), 32'(who));
            check("busy_en", 32'(mem_en), 32'd1);
            check("busy_we", 32'(mem_we), 32'(w));
            check("busy_addr", 32'(mem_addr), 32'(a));
            if (w) check("busy_wdata", 32'(mem_wdata), 32'(wd));
            check("busy_done", 32'({done1, done0}), 32'd0);
        end
        @(negedge clk);
        check("done_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("done_en", 32'({mem_en, mem_we}), 32'd0);
        check("done0", 32'(done0), 32'(!who));
        check("done1", 32'(done1), 32'(who));
        if (chk_rd) check("rdata", 32'(rdata), 32'(rd));
        @(posedge clk);
        #1;
        check("idle_done", 32'({done1, done0}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        {req0, req1, we0, we1} = 4'b0000;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_done", 32'({done1, done0}), 32'd0);
        check("rst_en", 32'(mem_en), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);

        // Single read by fetch
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 8'h10; we0 = 1'b0; mem_rdata = 8'hA5;
        expect_txn(1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'hA5);
        req0 = 1'b0;

        // Write by data port
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C; mem_rdata = 8'h77;
        expect_txn(1'b1, 8'h20, 8'h3C, 1'b1, 1'b0, 8'h00);
        req1 = 1'b0;
        @(negedge clk);
        check("idle_en", 32'(mem_en), 32'd0);
        check("idle_wdata_mux", 32'(mem_wdata), 32'h3C);
        check("rdata_hold", 32'(rdata), 32'h77);
        @(posedge clk); #1;

        // Contention: both held high, last served was 1 -> 0,1,0,1
        req0 = 1'b1; addr0 = 8'h11; we0 = 1'b0; wdata0 = 8'h00;
        req1 = 1'b1; addr1 = 8'h22; we1 = 1'b1; wdata1 = 8'h99; mem_rdata = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            expect_txn(1'(k % 2), (k % 2) ? 8'h22 : 8'h11, 8'h99, 1'(k % 2), !1'(k % 2), 8'h5A);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Async reset in the first BUSY cycle of a read
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 8'h40; we0 = 1'b0; mem_rdata = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        check("mid_gnt0_pre", 32'(gnt0), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_gnt0", 32'(gnt0), 32'd0);
        check("mid_en", 32'(mem_en), 32'd0);
        check("mid_rdata", 32'(rdata), 32'h00);
        @(posedge clk); #1 rst = 1'b0;
        check("mid_done", 32'({done1, done0}), 32'd0);
        expect_txn(1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'hC3);
        req0 = 1'b0;

`ifdef MEM_ARB_PERF_CNT_EN
        // Counters: 5 contended transactions after reset -> 3 fetch, 2 data grants
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("perf_rst", 32'(gcnt0), 32'd0);
        req0 = 1'b1; addr0 = 8'h01; we0 = 1'b0;
        req1 = 1'b1; addr1 = 8'h02; we1 = 1'b0; mem_rdata = 8'h11;
        for (int k = 0; k < 5; k++) begin
            expect_txn(1'(k % 2), (k % 2) ? 8'h02 : 8'h01, 8'h00, 1'b0, 1'b1, 8'h11);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("gcnt0", 32'(gcnt0), 32'd3);
        check("gcnt1", 32'(gcnt1), 32'd2);
        check("wcnt_nz", 32'(wcnt != 16'd0), 32'd1);
        @(negedge clk);
        force dut.gcnt0_q = 16'hFFFE;
        #1 release dut.gcnt0_q;
        req0 = 1'b1;
        expect_txn(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00);
        check("gcnt0_max", 32'(gcnt0), 32'hFFFF);
        expect_txn(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00);
        check("gcnt0_sat", 32'(gcnt0), 32'hFFFF);
        req0 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
